edge_event_arbiter: RTL
=======================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of asynchronous input channels (2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per channel (>=2).
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in  input  N_CH  asynchronous level inputs, one per channel.
REQ-006 SHALL have port evt_valid  output  1  event record available.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts record when high with evt_valid.
REQ-008 SHALL have port evt_ch  output  $clog2(N_CH)  channel index of presented event.
REQ-009 SHALL have port evt_rise  output  1  edge polarity: 1 = rising, 0 = falling.
REQ-010 SHALL have port overrun  output  N_CH  sticky per-channel lost-edge flags.
REQ-011 SHALL have port clr_overrun  input  1  synchronous pulse clearing all overrun bits.

Function
REQ-012 SHALL pass each in[i] through SYNC_STAGES flops, then compare the synchronized value with a registered previous sample; any difference is an edge (dual-edge detection).
REQ-013 SHALL, on a detected edge, set pending[i] and store pol[i] = new synchronized level at the next clock.
REQ-014 SHALL hold one output register (evt_valid/evt_ch/evt_rise); it is free when evt_valid=0 or when evt_valid&evt_ready this cycle.
REQ-015 SHALL, when the output register is free and any pending bit is set, grant exactly one channel: the first pending channel at or after round-robin pointer rr, searching upward with wrap from N_CH-1 to 0.
REQ-016 SHALL, on grant of channel c, load evt_ch=c, evt_rise=pol[c], evt_valid=1, clear pending[c], and set rr=(c+1) mod N_CH.
REQ-017 SHALL hold evt_valid, evt_ch, evt_rise stable while evt_valid=1 and evt_ready=0.
REQ-018 SHALL drop evt_valid on handshake if no channel is pending; with pending channels, SHALL reload the next grant the same clock (back-to-back, one event per cycle).
REQ-019 SHALL give latency: in change settled before rising edge t0 -> evt_valid high after edge t0+SYNC_STAGES+1 when the output register and channel are idle.
REQ-020 SHALL, when a new edge on channel i coincides with the grant of channel i, leave pending[i]=1 with the new polarity; no overrun.
REQ-021 SHALL, when a new edge arrives while pending[i]=1 and channel i is not granted that cycle, keep pending[i]=1, overwrite pol[i] with the newest level, and set overrun[i].
REQ-022 SHALL clear all overrun bits on clr_overrun; a same-cycle overrun set SHALL win over clear.
REQ-023 SHALL ignore evt_ready while evt_valid=0.

Reset
REQ-024 SHALL, while rst=0, asynchronously force synchronizer flops, previous samples, pending, pol, overrun, evt_valid, evt_ch, evt_rise to 0 and rr to 0.
REQ-025 SHALL, on reset release with any in[i]=1, report one rising event for channel i (previous sample was reset to 0).
REQ-026 SHALL, on reset asserted mid-handshake, discard the presented event and all pending events.

Structure
REQ-027 SHALL place the event record typedef (ch, rise), default N_CH and SYNC_STAGES in package edge_arb_pkg.
REQ-028 SHALL implement per-channel synchronizer, edge compare, pending/pol/overrun state in sub-module edge_chan, instantiated N_CH times via generate.
REQ-029 SHALL keep the round-robin search and output register in edge_event_arbiter.

Verification
REQ-030 SHALL cover a single edge: N_CH=4, evt_ready=1, in[2] 0->1 before edge t0 -> evt_valid at t0+3, evt_ch=2, evt_rise=1, one cycle only.
REQ-031 SHALL cover fairness: in[0..3] all rise same cycle, evt_ready=1 -> events ch 0,1,2,3 on consecutive cycles; then all fall -> order 0,1,2,3, all evt_rise=0.
REQ-032 SHALL cover backpressure: evt_ready=0 for 10 cycles with ch1 event presented -> outputs stable; on evt_ready=1 the next pending channel follows next cycle.
REQ-033 SHALL cover overrun: evt_ready=0, in[3] toggles 0->1->0 with 4-cycle spacing -> overrun[3]=1, a single ch3 event with evt_rise=0; clr_overrun -> overrun[3]=0.
REQ-034 SHALL cover wrap: rr=3 after a ch2 grant, ch1 and ch3 pending -> ch3 granted before ch1.
REQ-035 SHALL cover async reset: rst=0 mid-stream with evt_valid=1 -> evt_valid=0 immediately without a clock; release with in[0]=1 -> a single ch0 rising event.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge event arbiter.
// The record's channel field is sized for the largest supported channel count (16).
package edge_arb_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MAX_CH_W        = 4;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic                rise;
    } evt_rec_t;

endpackage

// File: rtl/edge_chan.sv
// One input channel: synchronizer, dual-edge detector and pending/polarity/overrun state.
module edge_chan
    import edge_arb_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic grant,
    input  logic clr_overrun,
    output logic pending,
    output logic pol,
    output logic overrun
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_q;
    logic                   synced;
    logic                   edge_det;
    logic                   lost;

    assign synced   = sync_p[SYNC_STAGES-1];
    assign edge_det = synced ^ prev_q;
    // An edge that lands on a grant of this same channel simply re-arms it; only
    // an edge stacking on an ungranted pending event loses information.
    assign lost     = edge_det & pending & ~grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p  <= '0;
            prev_q  <= 1'b0;
            pending <= 1'b0;
            pol     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], din};
            prev_q <= synced;
            if (edge_det) begin
                pending <= 1'b1;
                pol     <= synced;
            end else if (grant) begin
                pending <= 1'b0;
            end
            if (lost) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects edges from N_CH asynchronous level inputs and presents them one at a time
// through a valid/ready output register, granting channels in round-robin order.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_rise,
    output logic [N_CH-1:0]         overrun,
    input  logic                    clr_overrun
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pol;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] rr;
    logic [CH_W-1:0] gnt_idx;
    logic [CH_W-1:0] rr_next;
    logic            found;
    logic            free;
    evt_rec_t        evt_q;
    logic            unused_rec_ch;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .din         (in[i]),
            .grant       (grant[i]),
            .clr_overrun (clr_overrun),
            .pending     (pending[i]),
            .pol         (pol[i]),
            .overrun     (overrun[i])
        );
    end

    assign free = ~evt_valid | evt_ready;

    // First pending channel at or above rr, wrapping past the top channel.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && pending[CH_W'(idx)]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
        rr_next = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        grant   = '0;
        if (free && found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
            rr        <= '0;
        end else if (free) begin
            if (found) begin
                evt_valid  <= 1'b1;
                evt_q.ch   <= MAX_CH_W'(gnt_idx);
                evt_q.rise <= pol[gnt_idx];
                rr         <= rr_next;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign evt_ch        = evt_q.ch[CH_W-1:0];
    assign evt_rise      = evt_q.rise;
    assign unused_rec_ch = ^evt_q.ch;

endmodule
